mem_port_arbiter: RTL

//  Sits directly below the pipelined CPU core and merges its instruction-fetch and data ports

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Merges the core's instruction-fetch and data ports onto one shared memory port.
// Data has priority; fetch is guaranteed a grant after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_read,
    input  logic [31:0] inst_addr,
    output logic        inst_resp,
    output logic [31:0] inst_rdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_resp,
    output logic [31:0] data_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mbe,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_INST = 2'd1,
        SERVE_DATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] starve_r, starve_s;
    logic [31:0]      addr_r, addr_s;
    logic [31:0]      wdata_r, wdata_s;
    logic [3:0]       mbe_r, mbe_s;
    logic             write_r, write_s;
    logic             data_req_s;
    logic             fetch_due_s;

    // Arbitration, latching of the winner and response routing.
    always_comb begin
        state_s     = state_r;
        starve_s    = starve_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        mbe_s       = mbe_r;
        write_s     = write_r;
        data_req_s  = data_read | data_write;
        fetch_due_s = inst_read & (starve_r >= LIMIT);
        inst_resp   = 1'b0;
        inst_rdata  = 32'h0000_0000;
        data_resp   = 1'b0;
        data_rdata  = 32'h0000_0000;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_mbe     = 4'h0;
        mem_addr    = 32'h0000_0000;
        mem_wdata   = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (data_req_s && !fetch_due_s) begin
                    state_s = SERVE_DATA;
                    addr_s  = data_addr;
                    write_s = data_write;
                    mbe_s   = data_write ? data_mbe : 4'hF;
                    wdata_s = data_write ? data_wdata : 32'h0000_0000;
                    // Only data wins that actually bypass a waiting fetch count toward starvation.
                    if (inst_read) begin
                        starve_s = (starve_r >= LIMIT) ? LIMIT : starve_r + CNT_W'(1);
                    end else begin
                        starve_s = {CNT_W{1'b0}};
                    end
                end else if (inst_read) begin
                    state_s  = SERVE_INST;
                    addr_s   = inst_addr;
                    write_s  = 1'b0;
                    mbe_s    = 4'hF;
                    wdata_s  = 32'h0000_0000;
                    starve_s = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            SERVE_INST: begin
                mem_read = 1'b1;
                mem_mbe  = mbe_r;
                mem_addr = addr_r;
                if (mem_resp) begin
                    inst_resp  = 1'b1;
                    inst_rdata = mem_rdata;
                    state_s    = IDLE;
                end else begin
                    state_s = SERVE_INST;
                end
            end
            SERVE_DATA: begin
                mem_read  = ~write_r;
                mem_write = write_r;
                mem_mbe   = mbe_r;
                mem_addr  = addr_r;
                mem_wdata = wdata_r;
                if (mem_resp) begin
                    data_resp  = 1'b1;
                    data_rdata = mem_rdata;
                    state_s    = IDLE;
                end else begin
                    state_s = SERVE_DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, starvation counter and latched request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            starve_r <= {CNT_W{1'b0}};
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            mbe_r    <= 4'h0;
            write_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            starve_r <= starve_s;
            addr_r   <= addr_s;
            wdata_r  <= wdata_s;
            mbe_r    <= mbe_s;
            write_r  <= write_s;
        end
    end

endmodule
